// File: rtl/mv_stream_reader.sv
// ============================================================================
// mv_stream_reader : re-emits a frame of packed motion vectors as a raster
// ordered valid/ready stream. Optional per-frame statistics: MV_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mv_stream_reader #(
   parameter int H         = 320,
   parameter int V         = 240,
   parameter int BLOCKSIZE = 8,
   parameter int BH        = H / BLOCKSIZE,
   parameter int BV        = V / BLOCKSIZE,
   parameter int N         = 12,
   parameter int BXW       = 6,
   parameter int BYW       = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frm_valid,
   output logic                frm_ready,
   input  logic [N*BH*BV-1:0]  vector_x,
   input  logic [N*BH*BV-1:0]  vector_y,
   output logic                mv_valid,
   input  logic                mv_ready,
   output logic [N-1:0]        mv_x,
   output logic [N-1:0]        mv_y,
   output logic [BXW-1:0]      mv_bx,
   output logic [BYW-1:0]      mv_by,
   output logic                mv_last,
   output logic                frm_done,
   output logic [10:0]         stat_nz,
   output logic [N+10:0]       stat_mag
);

   localparam int NB = BH * BV;
   localparam int IW = $clog2(NB);
   localparam int BW = $clog2(N * NB);

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [BXW-1:0]   r_bx;
   logic [BXW-1:0]   w_bx_nx;
   logic [BYW-1:0]   r_by;
   logic [BYW-1:0]   w_by_nx;
   logic [N-1:0]     r_x;
   logic [N-1:0]     r_y;
   logic             r_last;
   logic             r_done;
   logic             w_load;
   logic             w_done;
   logic             w_xfer;
   logic             w_last_nx;
   logic [IW-1:0]    w_idx;
   logic [BW-1:0]    w_base;

   always_comb begin
      w_state_nx = r_state;
      w_bx_nx    = r_bx;
      w_by_nx    = r_by;
      w_load     = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (frm_valid) begin
               w_state_nx = S_STREAM;
               w_bx_nx    = '0;
               w_by_nx    = '0;
               w_load     = 1'b1;
            end
         end
         S_STREAM: begin
            if (mv_ready) begin
               if (r_last) begin
                  w_state_nx = S_IDLE;
                  w_done     = 1'b1;
               end else begin
                  if (r_bx == BXW'(BH - 1)) begin
                     w_bx_nx = '0;
                     w_by_nx = r_by + 1'b1;
                  end else begin
                     w_bx_nx = r_bx + 1'b1;
                  end
                  w_load = 1'b1;
               end
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   // The upstream buses are held stable for the whole frame, so the next
   // block is selected straight from them rather than from a snapshot.
   assign w_idx     = IW'(w_by_nx) * IW'(BH) + IW'(w_bx_nx);
   assign w_base    = BW'(w_idx) * BW'(N);
   assign w_last_nx = (w_bx_nx == BXW'(BH - 1)) && (w_by_nx == BYW'(BV - 1));
   assign w_xfer    = (r_state == S_STREAM) && mv_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_bx    <= '0;
         r_by    <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_done  <= w_done;
         if (w_load) begin
            r_bx   <= w_bx_nx;
            r_by   <= w_by_nx;
            r_x    <= vector_x[w_base +: N];
            r_y    <= vector_y[w_base +: N];
            r_last <= w_last_nx;
         end else if (w_done) begin
            r_last <= 1'b0;
         end
      end
   end

   assign frm_ready = (r_state == S_IDLE);
   assign mv_valid  = (r_state == S_STREAM);
   assign mv_x      = r_x;
   assign mv_y      = r_y;
   assign mv_bx     = r_bx;
   assign mv_by     = r_by;
   assign mv_last   = r_last;
   assign frm_done  = r_done;

`ifdef MV_STATS_EN
   localparam int MW = N + 11;

   logic [10:0]   r_acc_nz;
   logic [10:0]   r_stat_nz;
   logic [10:0]   w_nz_sum;
   logic [MW-1:0] r_acc_mag;
   logic [MW-1:0] r_stat_mag;
   logic [MW-1:0] w_mag_sum;
   logic [N-1:0]  w_abs_x;
   logic [N-1:0]  w_abs_y;

   // Unsigned N-bit magnitude: the most negative value maps to 2^(N-1).
   assign w_abs_x   = r_x[N-1] ? (~r_x + 1'b1) : r_x;
   assign w_abs_y   = r_y[N-1] ? (~r_y + 1'b1) : r_y;
   assign w_nz_sum  = r_acc_nz + 11'((r_x != '0) || (r_y != '0));
   assign w_mag_sum = r_acc_mag + MW'(w_abs_x) + MW'(w_abs_y);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_acc_nz   <= '0;
         r_acc_mag  <= '0;
         r_stat_nz  <= '0;
         r_stat_mag <= '0;
      end else begin
         if ((r_state == S_IDLE) && frm_valid) begin
            r_acc_nz  <= '0;
            r_acc_mag <= '0;
         end else if (w_xfer) begin
            r_acc_nz  <= w_nz_sum;
            r_acc_mag <= w_mag_sum;
         end
         if (w_done) begin
            r_stat_nz  <= w_nz_sum;
            r_stat_mag <= w_mag_sum;
         end
      end
   end

   assign stat_nz  = r_stat_nz;
   assign stat_mag = r_stat_mag;
`else
   assign stat_nz  = '0;
   assign stat_mag = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mv_stream_reader.sv
// ============================================================================
// tb_mv_stream_reader : randomized self-checking bench for mv_stream_reader.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mv_stream_reader;

   localparam int BH  = 40;
   localparam int BV  = 30;
   localparam int N   = 12;
   localparam int BXW = 6;
   localparam int BYW = 5;
   localparam int NB  = BH * BV;

   logic              clk;
   logic              rst;
   logic              frm_valid;
   logic              frm_ready;
   logic [N*NB-1:0]   vx;
   logic [N*NB-1:0]   vy;
   logic              mv_valid;
   logic              mv_ready;
   logic [N-1:0]      mv_x;
   logic [N-1:0]      mv_y;
   logic [BXW-1:0]    mv_bx;
   logic [BYW-1:0]    mv_by;
   logic              mv_last;
   logic              frm_done;
   logic [10:0]       stat_nz;
   logic [N+10:0]     stat_mag;

   int r_checks = 0;
   int r_errors = 0;

   mv_stream_reader dut (
      .clk       (clk),
      .rst       (rst),
      .frm_valid (frm_valid),
      .frm_ready (frm_ready),
      .vector_x  (vx),
      .vector_y  (vy),
      .mv_valid  (mv_valid),
      .mv_ready  (mv_ready),
      .mv_x      (mv_x),
      .mv_y      (mv_y),
      .mv_bx     (mv_bx),
      .mv_by     (mv_by),
      .mv_last   (mv_last),
      .frm_done  (frm_done),
      .stat_nz   (stat_nz),
      .stat_mag  (stat_mag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      r_checks++;
      if (got !== exp) begin
         r_errors++;
         if (r_errors <= 40)
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic fill_ramp();
      logic [N-1:0] t;
      for (int i = 0; i < NB; i++) begin
         t = N'(i);
         vx[i*N +: N] = t;
         vy[i*N +: N] = -t;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < NB; i++) begin
         vx[i*N +: N] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         vy[i*N +: N] = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      end
   endtask

   // Reference statistics: plain signed arithmetic over the whole frame.
   task automatic model_stats(output int nz, output int mag);
      logic signed [N-1:0] sx, sy;
      int ax, ay;
      nz = 0;
      mag = 0;
      for (int i = 0; i < NB; i++) begin
         sx = vx[i*N +: N];
         sy = vy[i*N +: N];
         ax = sx;
         ay = sy;
         if (ax < 0) ax = -ax;
         if (ay < 0) ay = -ay;
         if (ax != 0 || ay != 0) nz++;
         mag += ax + ay;
      end
   endtask

   task automatic check_stats();
      int nz, mag;
      model_stats(nz, mag);
`ifdef MV_STATS_EN
      check("stat_nz", 32'(stat_nz), nz);
      check("stat_mag", 32'(stat_mag), mag);
`else
      check("stat_nz_off", 32'(stat_nz), 0);
      check("stat_mag_off", 32'(stat_mag), 0);
`endif
   endtask

   task automatic accept(input bit hold);
      check("accept_ready", 32'(frm_ready), 1);
      frm_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!hold) frm_valid = 1'b0;
   endtask

   // Called at the negedge where block 0 should be presented. Returns at the
   // negedge following the last transfer (or at beat abort_at, if >= 0).
   task automatic stream_frame(input bit rand_rdy, input bit poke, input int abort_at,
                               output int cycles);
      int idx;
      idx = 0;
      cycles = 0;
      while (idx < NB && cycles < 20000) begin
         if (abort_at >= 0 && idx == abort_at) return;
         check("mv_valid", 32'(mv_valid), 1);
         check("mv_x", 32'(mv_x), 32'(vx[idx*N +: N]));
         check("mv_y", 32'(mv_y), 32'(vy[idx*N +: N]));
         check("mv_bx", 32'(mv_bx), idx % BH);
         check("mv_by", 32'(mv_by), idx / BH);
         check("mv_last", 32'(mv_last), 32'(idx == NB - 1));
         check("busy_done", 32'(frm_done), 0);
         check("busy_ready", 32'(frm_ready), 0);
         mv_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if (poke) frm_valid = 1'($urandom_range(0, 1));
         @(posedge clk);
         if (mv_ready) idx++;
         @(negedge clk);
         cycles++;
      end
      if (poke) frm_valid = 1'b0;
      if (idx < NB) check("stream_timeout", idx, NB);
      check("end_done", 32'(frm_done), 1);
      check("end_ready", 32'(frm_ready), 1);
      check("end_valid", 32'(mv_valid), 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(frm_ready), 1);
      check({tag, "_valid"}, 32'(mv_valid), 0);
      check({tag, "_last"}, 32'(mv_last), 0);
      check({tag, "_done"}, 32'(frm_done), 0);
      check({tag, "_xy"}, {8'h0, mv_y, mv_x}, 0);
      check({tag, "_bxby"}, 32'({mv_by, mv_bx}), 0);
      check({tag, "_stats"}, 32'(stat_nz) | 32'(stat_mag), 0);
   endtask

   initial begin
      int cyc;
      rst       = 1'b0;
      frm_valid = 1'b0;
      mv_ready  = 1'b0;
      vx        = '0;
      vy        = '0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_reset_outputs("reset");
      end

      // Ramp frame, no back-pressure, with spot checks on known beats.
      fill_ramp();
      mv_ready = 1'b1;
      accept(1'b0);
      check("b0_x", 32'(mv_x), 0);
      begin : ramp
         int idx;
         idx = 0;
         cyc = 0;
         while (idx < NB && cyc < 5000) begin
            if (idx == 41) begin
               check("b41_bx", 32'(mv_bx), 1);
               check("b41_by", 32'(mv_by), 1);
               check("b41_x", 32'(mv_x), 41);
               check("b41_y", 32'(mv_y), 32'h0FD7);
            end
            if (idx == 1199) begin
               check("b1199_bx", 32'(mv_bx), 39);
               check("b1199_by", 32'(mv_by), 29);
            end
            check("ramp_valid", 32'(mv_valid), 1);
            check("ramp_x", 32'(mv_x), idx % 4096);
            check("ramp_last", 32'(mv_last), 32'(idx == 1199));
            @(posedge clk);
            idx++;
            @(negedge clk);
            cyc++;
         end
         check("ramp_cycles", cyc, 1200);
         check("ramp_done", 32'(frm_done), 1);
         check("ramp_ready", 32'(frm_ready), 1);
         check_stats();
         @(negedge clk);
         check("ramp_done_pulse", 32'(frm_done), 0);
         check("ramp_idle_valid", 32'(mv_valid), 0);
      end

      // Random vectors, random back-pressure, frm_valid noise while streaming.
      for (int f = 0; f < 2; f++) begin
         fill_random();
         accept(1'b0);
         stream_frame(1'b1, 1'b1, -1, cyc);
         check_stats();
         repeat (4) begin
            @(negedge clk);
            check("noise_idle_valid", 32'(mv_valid), 0);
            check("noise_idle_ready", 32'(frm_ready), 1);
         end
      end

      // Back-to-back frames with frm_valid held high.
      fill_random();
      mv_ready = 1'b1;
      accept(1'b1);
      stream_frame(1'b0, 1'b0, -1, cyc);
      check("b2b_cycles", cyc, NB);
      check_stats();
      @(posedge clk);
      @(negedge clk);
      stream_frame(1'b0, 1'b0, -1, cyc);
      frm_valid = 1'b0;
      check("b2b2_cycles", cyc, NB);
      check_stats();
      @(negedge clk);

      // Asynchronous reset in the middle of a frame.
      fill_random();
      accept(1'b0);
      stream_frame(1'b0, 1'b0, 500, cyc);
      check("abort_bx", 32'(mv_bx), 500 % BH);
      rst = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (2) begin
         @(negedge clk);
         check("abort_no_done", 32'(frm_done), 0);
      end
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("abort_rel");
      accept(1'b0);
      stream_frame(1'b1, 1'b0, -1, cyc);
      check_stats();
      @(negedge clk);

      // Sparse frame with the most negative component.
      vx = '0;
      vy = '0;
      vx[5*N +: N] = 12'd3;
      vy[5*N +: N] = 12'hFFC;
      vx[7*N +: N] = 12'h800;
      mv_ready = 1'b1;
      accept(1'b0);
      stream_frame(1'b0, 1'b0, -1, cyc);
`ifdef MV_STATS_EN
      check("sparse_nz", 32'(stat_nz), 2);
      check("sparse_mag", 32'(stat_mag), 2055);
`else
      check("sparse_nz_off", 32'(stat_nz), 0);
      check("sparse_mag_off", 32'(stat_mag), 0);
`endif
      repeat (3) @(negedge clk);
`ifdef MV_STATS_EN
      check("sparse_hold", 32'(stat_mag), 2055);
`else
      check("sparse_hold_off", 32'(stat_mag), 0);
`endif

      $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
      $finish;
   end

endmodule

`default_nettype wire
